// File: rtl/keypad_scan_encoder.sv
// 4x4 matrix keypad scanner: walks one active-low column per scan tick,
// debounces press/release of the selected row and emits the encoded key.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_SCAN     | stepping columns, waiting for any row to go low
// ST_DEBOUNCE | column frozen, counting stable low samples of latched row
// ST_HOLD     | key accepted, counting stable high samples to release it
module keypad_scan_encoder #(
    parameter int SCAN_DIV       = 10000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic [3:0] key_code_o,
    output logic       key_valid_o,
    output logic       key_held_o
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_MAX   = CW'(DEBOUNCE_TICKS);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HOLD     = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    sync1_q, sync1_d;
    logic [3:0]    sync2_q, sync2_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [CW-1:0] deb_cnt_q, deb_cnt_d;
    logic [CW-1:0] rel_cnt_q, rel_cnt_d;
    logic [3:0]    col_q, col_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;

    logic [3:0]    row_s;
    logic          tick;
    logic [1:0]    row_low;
    logic          latched_high;

    assign row_s        = sync2_q;
    assign tick         = (presc_q == PRESC_MAX);
    assign latched_high = row_s[row_idx_q];

    // Lowest-index low row wins when several rows are pulled down at once.
    always_comb begin
        row_low = 2'd0;
        if (!row_s[0])      row_low = 2'd0;
        else if (!row_s[1]) row_low = 2'd1;
        else if (!row_s[2]) row_low = 2'd2;
        else if (!row_s[3]) row_low = 2'd3;
    end

    always_comb begin
        state_d     = state_q;
        presc_d     = tick ? '0 : presc_q + PW'(1);
        sync1_d     = row_i;
        sync2_d     = sync1_q;
        col_idx_d   = col_idx_q;
        row_idx_d   = row_idx_q;
        deb_cnt_d   = deb_cnt_q;
        rel_cnt_d   = rel_cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;

        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (row_s == 4'hF) begin
                        col_idx_d = col_idx_q + 2'd1;
                    end else begin
                        row_idx_d = row_low;
                        if (DEB_MAX == CW'(1)) begin
                            deb_cnt_d   = '0;
                            rel_cnt_d   = '0;
                            key_code_d  = {row_low, col_idx_q};
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            state_d     = ST_HOLD;
                        end else begin
                            deb_cnt_d = CW'(1);
                            state_d   = ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (!latched_high) begin
                        if (deb_cnt_q + CW'(1) == DEB_MAX) begin
                            deb_cnt_d   = '0;
                            rel_cnt_d   = '0;
                            key_code_d  = {row_idx_q, col_idx_q};
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            state_d     = ST_HOLD;
                        end else begin
                            deb_cnt_d = deb_cnt_q + CW'(1);
                        end
                    end else begin
                        deb_cnt_d = '0;
                        col_idx_d = col_idx_q + 2'd1;
                        state_d   = ST_SCAN;
                    end
                end
                ST_HOLD: begin
                    if (latched_high) begin
                        if (rel_cnt_q + CW'(1) == DEB_MAX) begin
                            rel_cnt_d  = '0;
                            key_held_d = 1'b0;
                            col_idx_d  = col_idx_q + 2'd1;
                            state_d    = ST_SCAN;
                        end else begin
                            rel_cnt_d = rel_cnt_q + CW'(1);
                        end
                    end else begin
                        rel_cnt_d = '0;
                    end
                end
                default: state_d = ST_SCAN;
            endcase
        end

        col_d = ~(4'b0001 << col_idx_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_SCAN;
            presc_q     <= '0;
            sync1_q     <= 4'hF;
            sync2_q     <= 4'hF;
            col_idx_q   <= 2'd0;
            row_idx_q   <= 2'd0;
            deb_cnt_q   <= '0;
            rel_cnt_q   <= '0;
            col_q       <= 4'b1110;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            col_idx_q   <= col_idx_d;
            row_idx_q   <= row_idx_d;
            deb_cnt_q   <= deb_cnt_d;
            rel_cnt_q   <= rel_cnt_d;
            col_q       <= col_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign col_o       = col_q;
    assign key_code_o  = key_code_q;
    assign key_valid_o = key_valid_q;
    assign key_held_o  = key_held_q;

endmodule
